// File: rtl/bcd_encoder_pkg.sv
// Shared widths, the BCD digit type and small helper functions for the
// decimal-to-BCD priority encoder.
package bcd_encoder_pkg;

    localparam int DEC_W = 10;
    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    // True when more than one decimal line is set. Clearing the lowest set
    // bit leaves something behind only if a second bit was present.
    function automatic logic popcount_gt1(input logic [DEC_W-1:0] d);
        return |(d & (d - DEC_W'(1)));
    endfunction

    // Even parity over a BCD digit: 1 when the digit has an odd number of ones.
    function automatic logic even_parity(input bcd_t v);
        return ^v;
    endfunction

endpackage

// File: rtl/bcd_prio_enc.sv
// Combinational 10-line priority encoder. PRIORITY_HIGH selects whether the
// highest or the lowest set line index wins when several lines are set.
module bcd_prio_enc
    import bcd_encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic [DEC_W-1:0] D,
    output bcd_t             code,
    output logic             any,
    output logic             multi
);

    // Scan the lines so that the winning index is the last one assigned.
    always_comb begin
        code = '0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < DEC_W; i++) begin
                code = D[i] ? bcd_t'(i) : code;
            end
        end else begin
            for (int i = DEC_W - 1; i >= 0; i--) begin
                code = D[i] ? bcd_t'(i) : code;
            end
        end
    end

    assign any   = |D;
    assign multi = popcount_gt1(D);

endmodule

// File: rtl/bcd_encoder.sv
// Registered 10-to-4 decimal-to-BCD priority encoder with empty and multi-hot
// flags. Define BCD_ENC_PARITY_EN to add the registered even-parity output
// bcd_par; without it the port and its logic are absent.
module bcd_encoder
    import bcd_encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DEC_W-1:0] D,
    output bcd_t             BCD,
    output logic             valid,
    output logic             multi
`ifdef BCD_ENC_PARITY_EN
    ,
    output logic             bcd_par
`endif
);

    bcd_t code_s;
    logic any_s;
    logic multi_s;

    bcd_prio_enc #(
        .PRIORITY_HIGH (PRIORITY_HIGH)
    ) u_prio (
        .D     (D),
        .code  (code_s),
        .any   (any_s),
        .multi (multi_s)
    );

    // Output registers: cleared asynchronously, loaded only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BCD   <= 4'd0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else if (en) begin
            BCD   <= code_s;
            valid <= any_s;
            multi <= multi_s;
        end else begin
            BCD   <= BCD;
            valid <= valid;
            multi <= multi;
        end
    end

`ifdef BCD_ENC_PARITY_EN
    // Parity is registered from the same encoded value so it tracks BCD exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_par <= 1'b0;
        end else if (en) begin
            bcd_par <= even_parity(code_s);
        end else begin
            bcd_par <= bcd_par;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_encoder.sv
// Self-checking bench for bcd_encoder. Two instances cover both priority
// directions; a queue of expected results is filled when stimulus is driven
// and drained one clock later when the registered outputs are sampled.
module tb_bcd_encoder;

    typedef struct packed {
        logic [3:0] bcd_hi;
        logic [3:0] bcd_lo;
        logic       valid;
        logic       multi;
        logic       par_hi;
        logic       par_lo;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] D;

    logic [3:0] bcd_hi, bcd_lo;
    logic       valid_hi, valid_lo, multi_hi, multi_lo;
`ifdef BCD_ENC_PARITY_EN
    logic       par_hi, par_lo;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t cur;

    bcd_encoder #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .D       (D),
        .BCD     (bcd_hi),
        .valid   (valid_hi),
        .multi   (multi_hi)
`ifdef BCD_ENC_PARITY_EN
        ,
        .bcd_par (par_hi)
`endif
    );

    bcd_encoder #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .D       (D),
        .BCD     (bcd_lo),
        .valid   (valid_lo),
        .multi   (multi_lo)
`ifdef BCD_ENC_PARITY_EN
        ,
        .bcd_par (par_lo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the behavioural description.
    function automatic exp_t model(input logic [9:0] d);
        exp_t e;
        int   hi, lo;
        hi = -1;
        lo = -1;
        for (int k = 9; k >= 0; k--) begin
            if (d[k] && hi < 0) hi = k;
        end
        for (int k = 0; k <= 9; k++) begin
            if (d[k] && lo < 0) lo = k;
        end
        e.bcd_hi = (hi < 0) ? 4'd0 : 4'(hi);
        e.bcd_lo = (lo < 0) ? 4'd0 : 4'(lo);
        e.valid  = (d != 10'd0);
        e.multi  = ($countones(d) > 1);
        e.par_hi = ^e.bcd_hi;
        e.par_lo = ^e.bcd_lo;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".bcd_hi"},   bcd_hi,           cur.bcd_hi);
        chk({tag, ".valid_hi"}, {3'd0, valid_hi}, {3'd0, cur.valid});
        chk({tag, ".multi_hi"}, {3'd0, multi_hi}, {3'd0, cur.multi});
        chk({tag, ".bcd_lo"},   bcd_lo,           cur.bcd_lo);
        chk({tag, ".valid_lo"}, {3'd0, valid_lo}, {3'd0, cur.valid});
        chk({tag, ".multi_lo"}, {3'd0, multi_lo}, {3'd0, cur.multi});
`ifdef BCD_ENC_PARITY_EN
        chk({tag, ".par_hi"},   {3'd0, par_hi},   {3'd0, cur.par_hi});
        chk({tag, ".par_lo"},   {3'd0, par_lo},   {3'd0, cur.par_lo});
`endif
    endtask

    task automatic drive(input logic e, input logic [9:0] d);
        @(negedge clk);
        en = e;
        D  = d;
        if (e) sb_q.push_back(model(d));
    endtask

    task automatic sample(input bit pop_it, input string tag);
        @(posedge clk);
        #1;
        if (pop_it) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL %s.queue observed=empty expected=entry", tag);
            end
            if (sb_q.size() > 0) cur = sb_q.pop_front();
        end
        compare_all(tag);
    endtask

    task automatic step(input logic e, input logic [9:0] d, input string tag);
        drive(e, d);
        sample(e, tag);
    endtask

    initial begin
        // 1. Reset with a live input: outputs must be zero immediately.
        rst_n = 1'b0;
        en    = 1'b1;
        D     = 10'b1000000000;
        cur   = '0;
        #1;
        compare_all("reset_imm");
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset_held");
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;

        // 2. Walk a single set line through every digit.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 10'b1 << k, $sformatf("walk%0d", k));
        end

        // 3. Multi-hot in both priority directions.
        step(1'b1, 10'b1100000000, "multi_top");
        step(1'b1, 10'b0000000110, "multi_low");
        step(1'b1, 10'b1111111111, "multi_all");
        step(1'b1, 10'b1000000001, "multi_ends");
        for (int r = 0; r < 6; r++) begin
            step(1'b1, 10'($urandom_range(1023, 0)), $sformatf("rand%0d", r));
        end

        // 4. Empty input, then hold while disabled, then resume.
        step(1'b1, 10'b0000000000, "empty");
        step(1'b1, 10'b0000000001, "digit0");
        step(1'b0, 10'b0000100000, "hold1");
        step(1'b0, 10'b0010000000, "hold2");
        step(1'b1, 10'b0000100000, "resume5");

        // 5. Parity-relevant digits.
        step(1'b1, 10'b0000001000, "par3");
        step(1'b1, 10'b0010000000, "par7");

        // 6. Asynchronous reset pulsed between clock edges.
        step(1'b1, 10'b0001000000, "pre_rst6");
        #2;
        rst_n = 1'b0;
        #1;
        cur = '0;
        compare_all("async_rst");
        #1;
        rst_n = 1'b1;
        sb_q.push_back(model(D));
        sample(1'b1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
